// File: rtl/multi_channel_pio.sv
// Multi-channel Avalon-MM GPIO: NUM_CH banks of WIDTH pins, each with direction,
// set/clear output, two-flop synchronised inputs, edge capture and a maskable irq.
module multi_channel_pio #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_MODE = 0,
    parameter logic [31:0] RESET_DIR = '0,
    parameter logic [31:0] RESET_OUT = '0,
    parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CH_W+2:0]         avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    inout  wire  [NUM_CH*WIDTH-1:0] pio_io,
    output logic [NUM_CH-1:0]       irq
);

    localparam int unsigned TOT = NUM_CH * WIDTH;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGECAP = 3'd3;
    localparam logic [2:0] REG_OUTSET  = 3'd4;
    localparam logic [2:0] REG_OUTCLR  = 3'd5;

    logic [TOT-1:0]    out_q, out_d;
    logic [TOT-1:0]    dir_q, dir_d;
    logic [TOT-1:0]    mask_q, mask_d;
    logic [TOT-1:0]    edgecap_q, edgecap_d;
    logic [TOT-1:0]    sync1_q, sync2_q, prev_q;
    logic [TOT-1:0]    edge_c;
    logic [NUM_CH-1:0] irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [2:0]        reg_idx;
    logic [CH_W-1:0]   ch_sel;
    logic [WIDTH-1:0]  wdata;
    logic              unused_wdata;

    assign reg_idx      = avs_address[2:0];
    assign ch_sel       = avs_address[CH_W+2:3];
    assign wdata        = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    // Tri-state pin drivers
    for (genvar i = 0; i < TOT; i++) begin : g_pin
        assign pio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        if (EDGE_MODE == 0) begin
            edge_c = sync2_q & ~prev_q;
        end else if (EDGE_MODE == 1) begin
            edge_c = ~sync2_q & prev_q;
        end else begin
            edge_c = sync2_q ^ prev_q;
        end
    end

    // Register writes, read mux and irq; channels beyond NUM_CH never match ch_sel
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        edgecap_d = edgecap_q;
        rdata_d   = rdata_q;
        irq_d     = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (avs_write && (ch_sel == CH_W'(c))) begin
                case (reg_idx)
                    REG_DATA:    out_d[c*WIDTH +: WIDTH]     = wdata;
                    REG_DIR:     dir_d[c*WIDTH +: WIDTH]     = wdata;
                    REG_IRQMASK: mask_d[c*WIDTH +: WIDTH]    = wdata;
                    REG_EDGECAP: edgecap_d[c*WIDTH +: WIDTH] = edgecap_q[c*WIDTH +: WIDTH] & ~wdata;
                    REG_OUTSET:  out_d[c*WIDTH +: WIDTH]     = out_q[c*WIDTH +: WIDTH] | wdata;
                    REG_OUTCLR:  out_d[c*WIDTH +: WIDTH]     = out_q[c*WIDTH +: WIDTH] & ~wdata;
                    default:     ;
                endcase
            end
        end

        // A fresh edge overrides a same-cycle W1C
        edgecap_d = edgecap_d | edge_c;

        if (avs_read) begin
            rdata_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == CH_W'(c)) begin
                    case (reg_idx)
                        REG_DATA:    rdata_d = 32'(sync2_q[c*WIDTH +: WIDTH]);
                        REG_DIR:     rdata_d = 32'(dir_q[c*WIDTH +: WIDTH]);
                        REG_IRQMASK: rdata_d = 32'(mask_q[c*WIDTH +: WIDTH]);
                        REG_EDGECAP: rdata_d = 32'(edgecap_q[c*WIDTH +: WIDTH]);
                        default:     rdata_d = '0;
                    endcase
                end
            end
        end

        for (int c = 0; c < NUM_CH; c++) begin
            irq_d[c] = |(edgecap_q[c*WIDTH +: WIDTH] & mask_q[c*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= {NUM_CH{RESET_OUT[WIDTH-1:0]}};
            dir_q     <= {NUM_CH{RESET_DIR[WIDTH-1:0]}};
            mask_q    <= '0;
            edgecap_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            irq_q     <= '0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
            sync1_q   <= pio_io;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_multi_channel_pio.sv
// Directed bench for multi_channel_pio: default 2x8 instance plus a 3x4 instance
// for out-of-range channel and width-masking behaviour.
module tb_multi_channel_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [3:0]  avs1_address = '0;
    logic        avs1_read = 1'b0;
    logic        avs1_write = 1'b0;
    logic [31:0] avs1_writedata = '0;
    logic [31:0] avs1_readdata;
    wire  [15:0] pio1;
    logic [1:0]  irq1;

    logic [4:0]  avs2_address = '0;
    logic        avs2_read = 1'b0;
    logic        avs2_write = 1'b0;
    logic [31:0] avs2_writedata = '0;
    logic [31:0] avs2_readdata;
    wire  [11:0] pio2;
    logic [2:0]  irq2;

    logic [15:0] tb_oe  = 16'hFFFF;
    logic [15:0] tb_val = 16'h0000;
    logic        tb2_oe = 1'b1;
    logic [11:0] tb2_val = 12'h5A5;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 16; i++) begin : g_tb1
        assign pio1[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end
    for (genvar i = 0; i < 12; i++) begin : g_tb2
        assign pio2[i] = tb2_oe ? tb2_val[i] : 1'bz;
    end

    multi_channel_pio u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs1_address),
        .avs_read      (avs1_read),
        .avs_write     (avs1_write),
        .avs_writedata (avs1_writedata),
        .avs_readdata  (avs1_readdata),
        .pio_io        (pio1),
        .irq           (irq1)
    );

    multi_channel_pio #(.NUM_CH(3), .WIDTH(4)) u_dut2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs2_address),
        .avs_read      (avs2_read),
        .avs_write     (avs2_write),
        .avs_writedata (avs2_writedata),
        .avs_readdata  (avs2_readdata),
        .pio_io        (pio2),
        .irq           (irq2)
    );

    task automatic bus1_write(input logic [3:0] a, input logic [31:0] d);
        avs1_address = a; avs1_writedata = d; avs1_write = 1'b1;
        @(posedge clk); #1;
        avs1_write = 1'b0;
    endtask

    task automatic bus1_read(input logic [3:0] a, output logic [31:0] d);
        avs1_address = a; avs1_read = 1'b1;
        @(posedge clk); #1;
        avs1_read = 1'b0;
        d = avs1_readdata;
    endtask

    task automatic bus2_write(input logic [4:0] a, input logic [31:0] d);
        avs2_address = a; avs2_writedata = d; avs2_write = 1'b1;
        @(posedge clk); #1;
        avs2_write = 1'b0;
    endtask

    task automatic bus2_read(input logic [4:0] a, output logic [31:0] d);
        avs2_address = a; avs2_read = 1'b1;
        @(posedge clk); #1;
        avs2_read = 1'b0;
        d = avs2_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        tb_oe = 16'hFFFF; tb_val = 16'h3C96;
        repeat (2) @(posedge clk); #1;
        checks++; if (pio1 !== 16'h3C96) $display("FAIL reset_pins_z: got %h expected %h", pio1, 16'h3C96); else passed++;
        checks++; if (irq1 !== 2'b00) $display("FAIL reset_irq: got %b expected %b", irq1, 2'b00); else passed++;
        checks++; if (avs1_readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected %h", avs1_readdata, 32'h0); else passed++;
        tb_val = 16'h0000;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            for (int r = 1; r <= 3; r++) begin
                bus1_read(4'((c << 3) | r), d);
                checks++;
                if (d !== 32'h0) $display("FAIL reset_reg ch%0d idx%0d: got %h expected %h", c, r, d, 32'h0);
                else passed++;
            end
        end
    endtask

    task automatic test_output_drive();
        logic [31:0] d;
        bus1_write(4'h9, 32'h0000_00FF);
        tb_oe[15:8] = 8'h00;
        bus1_write(4'h8, 32'h0000_00A5);
        checks++; if (pio1[15:8] !== 8'hA5) $display("FAIL drive_data: got %h expected %h", pio1[15:8], 8'hA5); else passed++;
        bus1_write(4'hC, 32'h0000_000A);
        checks++; if (pio1[15:8] !== 8'hAF) $display("FAIL drive_outset: got %h expected %h", pio1[15:8], 8'hAF); else passed++;
        bus1_write(4'hD, 32'h0000_00A0);
        checks++; if (pio1[15:8] !== 8'h0F) $display("FAIL drive_outclr: got %h expected %h", pio1[15:8], 8'h0F); else passed++;
        checks++; if (pio1[7:0] !== 8'h00) $display("FAIL drive_ch0_untouched: got %h expected %h", pio1[7:0], 8'h00); else passed++;
        repeat (2) @(posedge clk); #1;
        bus1_read(4'h8, d);
        checks++; if (d !== 32'h0000_000F) $display("FAIL drive_readback: got %h expected %h", d, 32'h0000_000F); else passed++;
        bus1_read(4'hC, d);
        checks++; if (d !== 32'h0) $display("FAIL outset_reads_zero: got %h expected %h", d, 32'h0); else passed++;
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        bus1_write(4'h2, 32'h1);
        tb_val[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus1_read(4'h3, d);
        checks++; if (d !== 32'h0) $display("FAIL edgecap_not_yet: got %h expected %h", d, 32'h0); else passed++;
        checks++; if (irq1 !== 2'b00) $display("FAIL irq_not_yet: got %b expected %b", irq1, 2'b00); else passed++;
        bus1_read(4'h3, d);
        checks++; if (d !== 32'h1) $display("FAIL edgecap_rise: got %h expected %h", d, 32'h1); else passed++;
        checks++; if (irq1 !== 2'b01) $display("FAIL irq_rise: got %b expected %b", irq1, 2'b01); else passed++;
        bus1_write(4'h3, 32'h1);
        checks++; if (irq1 !== 2'b01) $display("FAIL irq_hold_w1c: got %b expected %b", irq1, 2'b01); else passed++;
        @(posedge clk); #1;
        checks++; if (irq1 !== 2'b00) $display("FAIL irq_clear_w1c: got %b expected %b", irq1, 2'b00); else passed++;
        tb_val[0] = 1'b0;
        repeat (5) @(posedge clk); #1;
        bus1_read(4'h3, d);
        checks++; if (d !== 32'h0) $display("FAIL fall_ignored: got %h expected %h", d, 32'h0); else passed++;
        checks++; if (irq1 !== 2'b00) $display("FAIL fall_no_irq: got %b expected %b", irq1, 2'b00); else passed++;
    endtask

    task automatic test_collision();
        logic [31:0] d;
        bus1_write(4'h2, 32'h9);
        tb_val[3] = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks++; if (irq1 !== 2'b01) $display("FAIL coll_first_irq: got %b expected %b", irq1, 2'b01); else passed++;
        tb_val[3] = 1'b0;
        repeat (4) @(posedge clk); #1;
        tb_val[3] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus1_write(4'h3, 32'h8);
        checks++; if (irq1 !== 2'b01) $display("FAIL coll_irq_at_write: got %b expected %b", irq1, 2'b01); else passed++;
        @(posedge clk); #1;
        checks++; if (irq1 !== 2'b01) $display("FAIL coll_irq_after: got %b expected %b", irq1, 2'b01); else passed++;
        bus1_read(4'h3, d);
        checks++; if (d !== 32'h8) $display("FAIL coll_edge_wins: got %h expected %h", d, 32'h8); else passed++;
        bus1_write(4'h3, 32'h8);
        @(posedge clk); #1;
        bus1_read(4'h3, d);
        checks++; if (d !== 32'h0) $display("FAIL coll_plain_w1c: got %h expected %h", d, 32'h0); else passed++;
        checks++; if (irq1 !== 2'b00) $display("FAIL coll_irq_cleared: got %b expected %b", irq1, 2'b00); else passed++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        bus2_write(5'h19, 32'h0000_00FF);
        bus2_write(5'h18, 32'h0000_000F);
        @(posedge clk); #1;
        checks++; if (pio2 !== 12'h5A5) $display("FAIL oor_pins: got %h expected %h", pio2, 12'h5A5); else passed++;
        bus2_read(5'h19, d);
        checks++; if (d !== 32'h0) $display("FAIL oor_read: got %h expected %h", d, 32'h0); else passed++;
        bus2_read(5'h09, d);
        checks++; if (d !== 32'h0) $display("FAIL oor_no_alias_ch1: got %h expected %h", d, 32'h0); else passed++;
        bus2_read(5'h01, d);
        checks++; if (d !== 32'h0) $display("FAIL oor_no_alias_ch0: got %h expected %h", d, 32'h0); else passed++;
        bus2_read(5'h06, d);
        checks++; if (d !== 32'h0) $display("FAIL reserved_dut2: got %h expected %h", d, 32'h0); else passed++;
        bus1_read(4'h6, d);
        checks++; if (d !== 32'h0) $display("FAIL reserved_dut1: got %h expected %h", d, 32'h0); else passed++;
        bus2_write(5'h00, 32'h0000_0005);
        bus2_write(5'h01, 32'hFFFF_FFFF);
        bus2_read(5'h01, d);
        checks++; if (d !== 32'h0000_000F) $display("FAIL width_mask: got %h expected %h", d, 32'h0000_000F); else passed++;
        checks++; if (pio2 !== 12'h5A5) $display("FAIL width_pins: got %h expected %h", pio2, 12'h5A5); else passed++;
        checks++; if (irq2 !== 3'b000) $display("FAIL dut2_irq: got %b expected %b", irq2, 3'b000); else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        bus1_write(4'h8, 32'h0000_00A5);
        bus1_write(4'h2, 32'h0000_00FF);
        tb_val[1] = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks++; if (irq1 !== 2'b01) $display("FAIL ar_irq_before: got %b expected %b", irq1, 2'b01); else passed++;
        bus1_read(4'h8, d);
        checks++; if (d !== 32'h0000_00A5) $display("FAIL ar_data_before: got %h expected %h", d, 32'h0000_00A5); else passed++;
        checks++; if (pio1[15:8] !== 8'hA5) $display("FAIL ar_pins_before: got %h expected %h", pio1[15:8], 8'hA5); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (irq1 !== 2'b00) $display("FAIL ar_irq_async: got %b expected %b", irq1, 2'b00); else passed++;
        checks++; if (avs1_readdata !== 32'h0) $display("FAIL ar_readdata_async: got %h expected %h", avs1_readdata, 32'h0); else passed++;
        tb_oe = 16'hFFFF; tb_val = 16'h5A00;
        #1;
        checks++; if (pio1[15:8] !== 8'h5A) $display("FAIL ar_pins_z: got %h expected %h", pio1[15:8], 8'h5A); else passed++;
        tb_val = 16'h0000;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        bus1_read(4'h9, d);
        checks++; if (d !== 32'h0) $display("FAIL ar_dir: got %h expected %h", d, 32'h0); else passed++;
        bus1_read(4'h2, d);
        checks++; if (d !== 32'h0) $display("FAIL ar_mask: got %h expected %h", d, 32'h0); else passed++;
        bus1_read(4'h3, d);
        checks++; if (d !== 32'h0) $display("FAIL ar_edgecap: got %h expected %h", d, 32'h0); else passed++;
        checks++; if (irq1 !== 2'b00) $display("FAIL ar_irq_after: got %b expected %b", irq1, 2'b00); else passed++;
    endtask

    initial begin
        test_reset();
        test_output_drive();
        test_edge_irq();
        test_collision();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multi_channel_pio.md
Name: multi_channel_pio

Overview:
- Parametrised successor to the fixed per-CPU 4-bit and shared 8-bit PIOs.
- One Avalon-MM slave serves NUM_CH independent GPIO channels. Each channel is WIDTH bits wide, with per-bit direction, output set/clear, synchronised inputs, edge capture and a per-channel maskable interrupt.
- Lets several CPUs own private pin banks, or share one bank, through a single component in the SoC.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- WIDTH, 8, bits per channel (1..32).
- EDGE_MODE, 0, edge-capture type: 0 = rising, 1 = falling, 2 = any.
- RESET_DIR, 0, reset value of every channel DIR register (1 = output).
- RESET_OUT, 0, reset value of every channel output register.
- CH_W, max(1, clog2(NUM_CH)), channel-select address bits (derived).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- avs_address  input  CH_W+3  {channel, register index}.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data; bits [WIDTH-1:0] used.
- avs_readdata  output  32  read data; valid 1 cycle after avs_read.
- pio_io  inout  NUM_CH*WIDTH  pins; channel c occupies bits [c*WIDTH +: WIDTH].
- irq  output  NUM_CH  per-channel level interrupt.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: assertion clears all state immediately, deassertion is clocked by clk.
- Reset values:
  - out = RESET_OUT, dir = RESET_DIR.
  - mask = 0, edgecap = 0.
  - Sync flops and prev = 0.
  - avs_readdata = 0, irq = 0.
- Pin drive: pio_io bit = out bit when the dir bit is 1, else Z.
- Input path: every pin goes through sync1 -> sync2 (2 flops), then prev = sync2 delayed 1 cycle. All NUM_CH*WIDTH bits are treated identically.
- Edge detection (combinational):
  - Rising: sync2 & ~prev.
  - Falling: ~sync2 & prev.
  - Any: sync2 ^ prev.
  - An edge sets the matching edgecap bit at the next clk edge, for both input and output bits.
- Latency: a pin change meeting setup before edge k sets edgecap at edge k+2, and irq at edge k+3.
- Register map, per channel (index = avs_address[2:0], channel = avs_address[CH_W+2:3]):
  - 0 DATA: read returns sync2; write loads out.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns capture bits; write 1 clears a bit (W1C).
  - 4 OUTSET: write sets out bits where data is 1; reads as 0.
  - 5 OUTCLR: write clears out bits where data is 1; reads as 0.
  - 6, 7: reserved; read 0, writes ignored.
- Width rules: read bits [31:WIDTH] are 0; write bits [31:WIDTH] are ignored.
- Channel index >= NUM_CH: reads return 0, writes have no effect.
- Read latency is fixed at 1 cycle with no waitrequest. avs_readdata is registered and holds its value when avs_read is low.
- Simultaneous avs_read and avs_write: the write is performed; readdata returns the pre-write value.
- Simultaneous new edge and W1C on the same bit: the edge wins, so the bit stays 1.
- irq[c] is registered: irq[c] = |(edgecap_c & mask_c). It deasserts 1 cycle after the last contributing bit is cleared or masked.
- Changing DIR does not clear edgecap. A direction flip may create an edge that is captured normally.
- Reset mid-operation: all registers return to reset values at once, pins tri-state per RESET_DIR, and any pending read is discarded.

Test Plan:
1. Reset with defaults: all pio_io are Z, irq = 0. Reads of DIR/IRQMASK/EDGECAP on ch0 and ch1 return 0x00.
2. Output drive: write DIR ch1 = 0xFF, DATA ch1 = 0xA5 -> pio_io[15:8] = 0xA5 next cycle. Then OUTSET 0x0A -> 0xAF, and OUTCLR 0xA0 -> 0x0F. Reading DATA ch1 returns 0x0F 2 cycles after the pins settle.
3. Edge and irq (EDGE_MODE 0, ch0): IRQMASK = 0x01; drive pio_io[0] 0->1 before edge k -> EDGECAP bit0 = 1 at k+2, irq[0] = 1 at k+3. A 1->0 change captures nothing. W1C 0x01 -> irq[0] = 0 one cycle after the write.
4. Collision: issue a W1C to bit 3 in the same cycle a rising edge is detected on bit 3 -> bit 3 stays 1 and irq stays asserted.
5. Out-of-range and reserved addresses: with NUM_CH = 3, write channel 3 DIR = 0xFF -> no pin change, read returns 0. Reads of index 6 on ch0 return 0. With WIDTH = 4, writing 0xFFFFFFFF to DIR reads back 0x0000000F.
6. Async reset mid-operation: assert reset_n low between clock edges while driving 0xA5 -> pins go Z and irq goes 0 immediately, without waiting for clk. After release, registers read their reset values.
